// File: rtl/tt_eval_pkg.sv
// Shared types and helpers for the programmable truth-table evaluator and
// the scoring logic that reuses its lookup.
package tt_eval_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_SWEEP} tt_state_t;

  localparam int MAX_N_IN = 6;

  // Tables are stored MSB-first: the all-zeros vector selects the top bit.
  function automatic int unsigned tt_index(input int unsigned vec, input int unsigned tt_w);
    return tt_w - 1 - vec;
  endfunction

endpackage

// File: rtl/tt_lut.sv
// Combinational truth-table lookup: selects the table bit addressed by an
// N_IN-bit input vector.
module tt_lut
  import tt_eval_pkg::*;
#(
  parameter int N_IN = 3,
  localparam int TT_W = 1 << N_IN
) (
  input  logic [TT_W-1:0] tt_i,
  input  logic [N_IN-1:0] vec_i,
  output logic            bit_o
);

  logic [N_IN-1:0] idx;

  assign idx   = N_IN'(tt_index(32'(vec_i), TT_W));
  assign bit_o = tt_i[idx];

endmodule

// File: rtl/prog_truth_table_eval.sv
// Runtime-programmable N-input truth-table evaluator with a valid/ready
// stream, a single-register output stage and an exhaustive sweep mode.
module prog_truth_table_eval
  import tt_eval_pkg::*;
#(
  parameter int                      N_IN    = 3,
  parameter logic [(1<<N_IN)-1:0]    INIT_TT = 8'hC0,
  localparam int                     TT_W    = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [TT_W-1:0] cfg_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [N_IN-1:0] out_vec,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done
);

  // One value past the last vector; the extra counter bit keeps it from wrapping to 0.
  localparam logic [N_IN:0] CNT_END = (N_IN+1)'(TT_W);

  tt_state_t       state_q;
  logic [TT_W-1:0] table_q;
  logic            out_valid_q;
  logic            out_bit_q;
  logic [N_IN-1:0] out_vec_q;
  logic            sweep_done_q;
  logic [N_IN:0]   cnt_q;
  logic [N_IN:0]   cnt_d;

  logic            stage_free;
  logic            cfg_fire;
  logic            in_fire;
  logic            sweep_load;
  logic            sweep_last;
  logic            load_en;
  logic [N_IN-1:0] load_vec;
  logic            lut_bit;

  assign stage_free = !out_valid_q || out_ready;
  assign in_ready   = (state_q == ST_IDLE) && stage_free && !cfg_valid;
  assign cfg_ready  = (state_q == ST_IDLE) && !out_valid_q;
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign in_fire    = in_valid && in_ready;

  assign sweep_load = (state_q == ST_SWEEP) && stage_free && (cnt_q != CNT_END);
  assign sweep_last = (state_q == ST_SWEEP) && (cnt_q == CNT_END) && out_valid_q && out_ready;
  assign cnt_d      = cnt_q + 1'b1;

  assign load_en  = in_fire || sweep_load;
  assign load_vec = sweep_load ? cnt_q[N_IN-1:0] : in_vec;

  tt_lut #(.N_IN(N_IN)) u_lut (
    .tt_i  (table_q),
    .vec_i (load_vec),
    .bit_o (lut_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      table_q      <= INIT_TT;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_vec_q    <= '0;
      sweep_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sweep_done_q <= 1'b0;

      if (load_en) begin
        out_valid_q <= 1'b1;
        out_bit_q   <= lut_bit;
        out_vec_q   <= load_vec;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A config handshake in the same cycle swallows any sweep_start.
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_fire) begin
            table_q <= cfg_data;
          end else if (sweep_start) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
          end
        end
        ST_SWEEP: begin
          if (sweep_load) cnt_q <= cnt_d;
          if (sweep_last) begin
            state_q      <= ST_IDLE;
            sweep_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_vec    = out_vec_q;
  assign sweep_busy = (state_q == ST_SWEEP);
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_prog_truth_table_eval.sv
// Scoreboard bench for prog_truth_table_eval: expected results are queued
// at stimulus time and compared as the DUT hands them out.
module tb_prog_truth_table_eval;

  localparam logic [7:0] INIT_TT = 8'hC0;

  typedef struct packed {
    logic [2:0] vec;
    logic       bitv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_vec = 3'b000;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_bit;
  logic [2:0] out_vec;
  logic       sweep_start = 1'b0;
  logic       sweep_busy;
  logic       sweep_done;

  exp_t       expQ[$];
  exp_t       popped;
  logic [7:0] tbTable = INIT_TT;
  logic [2:0] lastAccVec = 3'b000;
  logic       toggleReady = 1'b0;
  int         vectorsApplied = 0;
  int         miscompares = 0;
  int         sweepDoneCount = 0;

  prog_truth_table_eval #(.N_IN(3), .INIT_TT(INIT_TT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bit     (out_bit),
    .out_vec     (out_vec),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Vector 000 addresses the table MSB, vector 111 the LSB.
  function automatic logic expBit(input logic [2:0] v);
    logic [2:0] pos;
    pos = ~v;
    return tbTable[pos];
  endfunction

  // Results are consumed on the negedge before the edge that completes the handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 32'(out_vec), 32'hFFFF_FFFF);
      end else begin
        popped = expQ.pop_front();
        checkOutput("out_vec", 32'(out_vec), 32'(popped.vec));
        checkOutput("out_bit", 32'(out_bit), 32'(popped.bitv));
        lastAccVec = out_vec;
      end
    end
    if (rst_n && sweep_done) begin
      sweepDoneCount++;
      checkOutput("done_after_last_vec", 32'(lastAccVec), 32'd7);
      checkOutput("done_queue_empty", 32'(expQ.size()), 32'd0);
    end
  end

  always @(posedge clk) begin
    #2;
    if (toggleReady) out_ready = ~out_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v);
    int waited;
    in_valid = 1'b1;
    in_vec   = v;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      expQ.push_back('{vec: v, bitv: expBit(v)});
      tick();
      in_valid = 1'b0;
      checkOutput("latency_valid", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic applyCfg(input logic [7:0] data);
    int waited;
    cfg_valid = 1'b1;
    cfg_data  = data;
    waited    = 0;
    @(negedge clk);
    while (!cfg_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!cfg_ready) checkOutput("cfg_ready_timeout", 32'd0, 32'd1);
    tick();
    tbTable   = data;
    cfg_valid = 1'b0;
  endtask

  task automatic pulseSweep(input logic pushExpected);
    sweep_start = 1'b1;
    if (pushExpected)
      for (int i = 0; i < 8; i++) expQ.push_back('{vec: 3'(i), bitv: expBit(3'(i))});
    tick();
    sweep_start = 1'b0;
  endtask

  task automatic waitSweepDone();
    int waited;
    waited = 0;
    while (sweepDoneCount == 0 && waited < 200) begin
      waited++;
      tick();
    end
    if (sweepDoneCount == 0) checkOutput("sweep_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle handshake state.
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    checkOutput("rst_sweep_busy", 32'(sweep_busy), 32'd0);

    // Default table over every vector.
    for (int i = 0; i < 8; i++) applyStimulus(3'(i));
    tick();

    // cfg_ready must stay low while a result is pending.
    out_ready = 1'b0;
    applyStimulus(3'b011);
    checkOutput("cfg_ready_pending", 32'(cfg_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    applyCfg(8'h96);
    applyStimulus(3'b111);
    applyStimulus(3'b110);
    applyStimulus(3'b001);
    tick();

    // Back-pressure: stage full blocks the next vector and holds the output.
    out_ready = 1'b0;
    applyStimulus(3'b010);
    in_valid = 1'b1;
    in_vec   = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_vec", 32'(out_vec), 32'd2);
      checkOutput("bp_out_bit", 32'(out_bit), 32'(expBit(3'b010)));
    end
    tick();
    out_ready = 1'b1;
    applyStimulus(3'b101);
    tick();
    checkOutput("bp_queue_drained", 32'(expQ.size()), 32'd0);

    // Config beats an input vector in the same cycle.
    in_valid  = 1'b1;
    in_vec    = 3'b000;
    cfg_valid = 1'b1;
    cfg_data  = INIT_TT;
    @(negedge clk);
    checkOutput("prio_in_ready", 32'(in_ready), 32'd0);
    checkOutput("prio_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    tbTable   = INIT_TT;
    cfg_valid = 1'b0;
    applyStimulus(3'b001);
    tick();

    // Sweep under toggling back-pressure, with a stray restart request.
    sweepDoneCount = 0;
    toggleReady = 1'b1;
    pulseSweep(1'b1);
    checkOutput("sweep_busy", 32'(sweep_busy), 32'd1);
    checkOutput("sweep_in_ready", 32'(in_ready), 32'd0);
    repeat (3) tick();
    pulseSweep(1'b0);
    waitSweepDone();
    toggleReady = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    checkOutput("sweep_done_once", 32'(sweepDoneCount), 32'd1);
    checkOutput("sweep_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("sweep_exit_busy", 32'(sweep_busy), 32'd0);

    // Reset mid-sweep discards the loaded table.
    applyCfg(8'h96);
    toggleReady = 1'b1;
    pulseSweep(1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_out_bit", 32'(out_bit), 32'd0);
    checkOutput("arst_out_vec", 32'(out_vec), 32'd0);
    checkOutput("arst_sweep_busy", 32'(sweep_busy), 32'd0);
    checkOutput("arst_sweep_done", 32'(sweep_done), 32'd0);
    expQ.delete();
    tbTable = INIT_TT;
    toggleReady = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    applyStimulus(3'b000);
    applyStimulus(3'b001);
    applyStimulus(3'b010);
    repeat (3) tick();
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
